varredura_servo: RTL and testbench

//   Position sequencer directly upstream of controle_servo; drives its 2-bit posicao input.

---
 rtl/servo_pkg.sv | 40 ++++
 rtl/contador_dwell.sv | 41 ++++
 rtl/varredura_servo.sv | 150 +++++++++++++++
 tb/tb_varredura_servo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the servo position sequencer.
// Holds the posicao codes understood by controle_servo, the sequencer FSM
// state codes (also shown on db_estado), the sweep direction type and the
// helper that computes the next position of the sweep.
package servo_pkg;

    // posicao codes driven into controle_servo
    localparam logic [1:0] POS_PARADO = 2'b00;  // no PWM pulse
    localparam logic [1:0] POS_1MS    = 2'b01;
    localparam logic [1:0] POS_1_5MS  = 2'b10;
    localparam logic [1:0] POS_2MS    = 2'b11;

    // Sequencer states; the encoding is visible on db_estado
    typedef enum logic [1:0] {
        ST_PARADO = 2'b00,
        ST_INICIO = 2'b01,
        ST_ESPERA = 2'b10,
        ST_PASSO  = 2'b11
    } estado_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Next position of the round trip 01 -> 10 -> 11 -> 10 -> 01.
    // Any illegal code (00 while running) recovers to the start of the sweep.
    function automatic logic [1:0] proxima_pos(input logic [1:0] pos, input dir_t dir);
        logic [1:0] nova;
        nova = POS_1MS;
        case (pos)
            POS_1MS:   nova = POS_1_5MS;
            POS_1_5MS: nova = (dir == DIR_UP) ? POS_2MS : POS_1MS;
            POS_2MS:   nova = POS_1_5MS;
            default:   nova = POS_1MS;
        endcase
        return nova;
    endfunction

endpackage

// File: rtl/contador_dwell.sv
// Dwell counter for the servo sequencer.
// Counts 0..M-1 while conta=1 and wraps back to 0 on the cycle it is at M-1,
// so it can never exceed M-1. zera clears synchronously and wins over conta.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   zera   in   synchronous clear
//   conta  in   count enable
//   fim    out  1 while Q == M-1
//   Q      out  current count
module contador_dwell #(
    parameter int M = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 zera,
    input  logic                 conta,
    output logic                 fim,
    output logic [$clog2(M)-1:0] Q
);

    localparam int W = $clog2(M);

    assign fim = (Q == W'(M - 1));

    // Count register: clear has priority, terminal count returns to zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            Q <= '0;
        end else if (zera) begin
            Q <= '0;
        end else if (conta) begin
            if (fim) begin
                Q <= '0;
            end else begin
                Q <= Q + W'(1);
            end
        end
    end

endmodule

// File: rtl/varredura_servo.sv
// Position sequencer feeding controle_servo.posicao.
// While ligar=1 it sweeps 01 -> 10 -> 11 -> 10 -> 01 ..., holding each
// position for DWELL_CYCLES counting cycles plus the one-cycle step.
// pausa freezes the dwell count; ligar=0 parks the servo at 00 (no pulse).
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   ligar          in   level enable (1 = sweep, 0 = park)
//   pausa          in   level, freezes the dwell counter
//   posicao        out  registered position code for controle_servo
//   muda_posicao   out  1-cycle pulse on the first cycle of a new position
//   fim_varredura  out  1-cycle pulse when the sweep returns to 01
//   db_estado      out  current FSM state code (debug)
module varredura_servo
    import servo_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       pausa,
    output logic [1:0] posicao,
    output logic       muda_posicao,
    output logic       fim_varredura,
    output logic [1:0] db_estado
);

    estado_t          estado_r, estado_s;
    logic [1:0]       posicao_r, posicao_s;
    dir_t             dir_r, dir_s;
    logic             muda_r, muda_s;
    logic             fim_r, fim_s;
    logic [1:0]       nova_pos_s;

    logic             conta_s;
    logic             zera_s;
    logic             dwell_fim_s;
    logic [CNT_W-1:0] cnt_s;
    logic             dwell_done_s;
    logic             avanca_s;

    // The counter only runs in ESPERA; every other state (and parking) holds it at zero
    assign conta_s = (estado_r == ST_ESPERA) && ligar && !pausa;
    assign zera_s  = !ligar || (estado_r != ST_ESPERA);

    contador_dwell #(
        .M (DWELL_CYCLES)
    ) u_contador_dwell (
        .clock (clock),
        .reset (reset),
        .zera  (zera_s),
        .conta (conta_s),
        .fim   (dwell_fim_s),
        .Q     (cnt_s)
    );

    // Terminal flag and raw count must agree before the sweep is allowed to advance
    assign dwell_done_s = dwell_fim_s && (cnt_s == CNT_W'(DWELL_CYCLES - 1));
    assign avanca_s     = (estado_r == ST_ESPERA) && dwell_done_s && !pausa;
    assign nova_pos_s   = proxima_pos(posicao_r, dir_r);

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r  <= ST_PARADO;
            posicao_r <= POS_PARADO;
            dir_r     <= DIR_UP;
            muda_r    <= 1'b0;
            fim_r     <= 1'b0;
        end else begin
            estado_r  <= estado_s;
            posicao_r <= posicao_s;
            dir_r     <= dir_s;
            muda_r    <= muda_s;
            fim_r     <= fim_s;
        end
    end

    // Next-state logic; dropping ligar parks from any state
    always_comb begin
        estado_s = estado_r;
        if (!ligar) begin
            estado_s = ST_PARADO;
        end else begin
            case (estado_r)
                ST_PARADO: estado_s = ST_INICIO;
                ST_INICIO: estado_s = ST_ESPERA;
                ST_ESPERA: estado_s = avanca_s ? ST_PASSO : ST_ESPERA;
                ST_PASSO:  estado_s = ST_ESPERA;
                default:   estado_s = ST_PARADO;
            endcase
        end
    end

    // Output logic: computes the value the outputs take together with the next
    // state, so the pulses land on the first cycle of the new position
    always_comb begin
        posicao_s = posicao_r;
        dir_s     = dir_r;
        muda_s    = 1'b0;
        fim_s     = 1'b0;
        if (!ligar) begin
            posicao_s = POS_PARADO;
            dir_s     = DIR_UP;
        end else begin
            case (estado_r)
                ST_PARADO: begin
                    // entering INICIO: always restart at 01 going up
                    posicao_s = POS_1MS;
                    dir_s     = DIR_UP;
                    muda_s    = 1'b1;
                end
                ST_INICIO, ST_PASSO: begin
                    posicao_s = posicao_r;
                    dir_s     = dir_r;
                end
                ST_ESPERA: begin
                    if (avanca_s) begin
                        posicao_s = nova_pos_s;
                        muda_s    = 1'b1;
                        if (nova_pos_s == POS_2MS) begin
                            dir_s = DIR_DOWN;
                        end else if (nova_pos_s == POS_1MS) begin
                            // only reachable on the way down: round trip complete
                            dir_s = DIR_UP;
                            fim_s = 1'b1;
                        end else begin
                            dir_s = dir_r;
                        end
                    end else begin
                        posicao_s = posicao_r;
                        dir_s     = dir_r;
                    end
                end
                default: begin
                    posicao_s = POS_PARADO;
                    dir_s     = DIR_UP;
                end
            endcase
        end
    end

    assign posicao       = posicao_r;
    assign muda_posicao  = muda_r;
    assign fim_varredura = fim_r;
    assign db_estado     = estado_r;

endmodule

// File: tb/tb_varredura_servo.sv
// Self-checking bench for varredura_servo with DWELL_CYCLES=4.
// A sequence-level model (position index into the round-trip table plus a
// count of unpaused dwell cycles) predicts every output; a negedge process
// compares it each cycle, and literal checks pin the model at key points.
module tb_varredura_servo;

    localparam int DWELL = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ligar = 1'b0;
    logic       pausa = 1'b0;
    logic [1:0] posicao;
    logic       muda_posicao;
    logic       fim_varredura;
    logic [1:0] db_estado;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int seq [4] = '{1, 2, 3, 2};
    bit m_running = 1'b0;
    bit m_just    = 1'b0;   // in the one-cycle INICIO/PASSO slot
    int m_idx     = 0;
    int m_done    = 0;      // unpaused dwell cycles since the slot
    int m_pos     = 0;
    int m_muda    = 0;
    int m_fim     = 0;
    int m_code    = 0;

    varredura_servo #(
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ligar         (ligar),
        .pausa         (pausa),
        .posicao       (posicao),
        .muda_posicao  (muda_posicao),
        .fim_varredura (fim_varredura),
        .db_estado     (db_estado)
    );

    always #10 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        m_running = 1'b0;
        m_just    = 1'b0;
        m_idx     = 0;
        m_done    = 0;
        m_pos     = 0;
        m_muda    = 0;
        m_fim     = 0;
        m_code    = 0;
    endtask

    // one rising edge of the model, using the inputs present at that edge
    task automatic model_edge(input logic l, input logic p);
        m_muda = 0;
        m_fim  = 0;
        if (!reset) begin
            model_zero();
        end else if (!l) begin
            model_zero();
        end else if (!m_running) begin
            m_running = 1'b1;
            m_idx     = 0;
            m_pos     = seq[0];
            m_muda    = 1;
            m_just    = 1'b1;
            m_done    = 0;
            m_code    = 1;
        end else if (m_just) begin
            m_just = 1'b0;
            m_done = 0;
            m_code = 2;
        end else begin
            if (!p) m_done++;
            if (m_done == DWELL) begin
                m_idx  = (m_idx + 1) % 4;
                m_pos  = seq[m_idx];
                m_muda = 1;
                m_fim  = (m_idx == 0) ? 1 : 0;
                m_just = 1'b1;
                m_done = 0;
                m_code = 3;
            end else begin
                m_code = 2;
            end
        end
    endtask

    task automatic step(input logic l, input logic p);
        ligar = l;
        pausa = p;
        @(posedge clock);
        model_edge(l, p);
        #1;
    endtask

    task automatic rst_assert();
        reset = 1'b0;
        model_zero();
        #1;
        chk("rst_pos", posicao, 0);
        chk("rst_db", db_estado, 0);
        chk("rst_muda", muda_posicao, 0);
        chk("rst_fim", fim_varredura, 0);
    endtask

    // cycle-by-cycle comparison against the model
    always @(negedge clock) begin
        chk("posicao", posicao, m_pos);
        chk("muda_posicao", muda_posicao, m_muda);
        chk("fim_varredura", fim_varredura, m_fim);
        chk("db_estado", db_estado, m_code);
    end

    initial begin
        int  r;
        logic l, p;

        repeat (2) @(posedge clock);
        #1;
        chk("init_pos", posicao, 0);
        chk("init_db", db_estado, 0);
        reset = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // sweep
        step(1'b1, 1'b0);
        chk("start_pos", posicao, 1);
        chk("start_muda", muda_posicao, 1);
        chk("start_db", db_estado, 1);
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0);
            if (k == 5)  chk("k5_pos", posicao, 2);
            if (k == 5)  chk("k5_db", db_estado, 3);
            if (k == 10) chk("k10_pos", posicao, 3);
            if (k == 15) chk("k15_pos", posicao, 2);
            if (k == 15) chk("k15_fim", fim_varredura, 0);
            if (k == 19) chk("k19_muda", muda_posicao, 0);
            if (k == 20) chk("k20_pos", posicao, 1);
            if (k == 20) chk("k20_fim", fim_varredura, 1);
            if (k == 20) chk("k20_muda", muda_posicao, 1);
        end

        // pause for 7 edges during ESPERA at 10: change moves from k=30 to k=37
        for (int k = 21; k <= 39; k++) begin
            step(1'b1, (k >= 27 && k <= 33));
            if (k == 25) chk("k25_pos", posicao, 2);
            if (k == 30) chk("pause_hold30", posicao, 2);
            if (k == 36) chk("pause_hold36", posicao, 2);
            if (k == 37) chk("pause_step_pos", posicao, 3);
            if (k == 37) chk("pause_step_muda", muda_posicao, 1);
            if (k == 39) chk("k39_db", db_estado, 2);
        end

        // disable during ESPERA at 11
        step(1'b0, 1'b0);
        chk("off_pos", posicao, 0);
        chk("off_db", db_estado, 0);
        chk("off_muda", muda_posicao, 0);

        // re-enable with pausa only in INICIO and PASSO cycles
        step(1'b1, 1'b0);
        chk("re_pos", posicao, 1);
        chk("re_db", db_estado, 1);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, (k == 1 || k == 6));
            if (k == 5)  chk("re5_pos", posicao, 2);
            if (k == 5)  chk("re5_db", db_estado, 3);
            if (k == 10) chk("re10_pos", posicao, 3);
            if (k == 10) chk("re10_muda", muda_posicao, 1);
        end

        // asynchronous reset mid-run, held for a few edges
        step(1'b1, 1'b0);
        rst_assert();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        chk("rst_hold_pos", posicao, 0);
        chk("rst_hold_db", db_estado, 0);
        reset = 1'b1;
        step(1'b1, 1'b0);
        chk("rst_rel_pos", posicao, 1);

        // randomized phase
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                rst_assert();
                step(1'b1, 1'b0);
                reset = 1'b1;
            end else begin
                l = ($urandom_range(0, 99) >= 3);
                p = ($urandom_range(0, 99) < 25);
                step(l, p);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
